// File: rtl/lfsr4_pkg.sv
// Shared definitions for the 4-bit x^4+x^3+1 LFSR generator/checker pair.
package lfsr4_pkg;

    localparam int unsigned LFSR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Single source of truth for the polynomial step used by both ends of the link.
    function automatic logic [LFSR_W-1:0] lfsr4_next(input logic [LFSR_W-1:0] v);
        return {v[2:0], v[3] ^ v[2]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds, locks and counts mismatches on a 4-bit stream.
// Optional macro LFSR_CHK_ERR_CLR_EN adds a synchronous err_clr input.
module lfsr_checker
    import lfsr4_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] data_in,
    input  logic              data_valid,
`ifdef LFSR_CHK_ERR_CLR_EN
    input  logic              err_clr,
`endif
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [LFSR_W-1:0] led
);

    localparam int unsigned CNT_W = 4;

    state_t              r_state;
    logic [LFSR_W-1:0]   r_expected;
    logic [LFSR_W-1:0]   r_last_data;
    logic [CNT_W-1:0]    r_match_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic                r_locked;
    logic                r_err_pulse;
    logic [ERR_W-1:0]    r_err_cnt;
    logic                w_match;
    logic                w_clr;

    assign w_match = (data_in == r_expected);

`ifdef LFSR_CHK_ERR_CLR_EN
    assign w_clr = err_clr;
`else
    assign w_clr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_expected  <= '0;
            r_last_data <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (data_valid) begin
                r_last_data <= data_in;
                case (r_state)
                    IDLE: begin
                        // All-zero is the LFSR lockup value and can never seed a sequence.
                        if (data_in != '0) begin
                            r_expected  <= lfsr4_next(data_in);
                            r_match_cnt <= CNT_W'(1);
                            r_state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (w_match) begin
                            r_expected  <= lfsr4_next(data_in);
                            r_match_cnt <= r_match_cnt + CNT_W'(1);
                            if ((r_match_cnt + CNT_W'(1)) == CNT_W'(LOCK_CNT)) begin
                                r_state    <= LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end
                        end else if (data_in != '0) begin
                            r_expected  <= lfsr4_next(data_in);
                            r_match_cnt <= CNT_W'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_expected <= lfsr4_next(data_in);
                            r_miss_cnt <= '0;
                        end else begin
                            // Free-run on our own prediction; the bad sample is not trusted.
                            r_expected  <= lfsr4_next(r_expected);
                            r_err_pulse <= 1'b1;
                            r_miss_cnt  <= r_miss_cnt + CNT_W'(1);
                            if (r_err_cnt != {ERR_W{1'b1}}) begin
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            end
                            if ((r_miss_cnt + CNT_W'(1)) == CNT_W'(UNLOCK_CNT)) begin
                                r_state  <= IDLE;
                                r_locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            // Clear takes priority over a same-cycle increment.
            if (w_clr) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign led       = r_locked ? r_err_cnt[LFSR_W-1:0] : r_last_data;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker; honours LFSR_CHK_ERR_CLR_EN when defined.
module tb_lfsr_checker;

    localparam int unsigned LOCK_CNT   = 3;
    localparam int unsigned UNLOCK_CNT = 2;
    localparam int unsigned ERR_W      = 8;
    localparam int          ERR_MAX    = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic [3:0]       data_in;
    logic             data_valid;
    logic             err_clr;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       led;

    typedef struct {
        logic             l;
        logic             p;
        logic [ERR_W-1:0] e;
        logic [3:0]       led;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: 0=IDLE 1=SYNC 2=LOCKED
    int m_state, m_exp, m_match, m_miss, m_err;

    lfsr_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT),
        .ERR_W     (ERR_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
`ifdef LFSR_CHK_ERR_CLR_EN
        .err_clr   (err_clr),
`endif
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nxt(input int v);
        return ((v * 2) % 16) + (((v / 8) + (v / 4)) % 2);
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = 0; m_match = 0; m_miss = 0; m_err = 0;
    endtask

    task automatic model_step(input int d, input bit clr);
        exp_t e;
        e.p = 1'b0;
        if (m_state == 0) begin
            if (d != 0) begin m_exp = nxt(d); m_match = 1; m_state = 1; end
        end else if (m_state == 1) begin
            if (d == m_exp) begin
                m_exp = nxt(d);
                m_match++;
                if (m_match == LOCK_CNT) begin m_state = 2; m_miss = 0; end
            end else if (d != 0) begin
                m_exp = nxt(d); m_match = 1;
            end else begin
                m_state = 0;
            end
        end else begin
            if (d == m_exp) begin
                m_exp = nxt(d); m_miss = 0;
            end else begin
                m_exp = nxt(m_exp);
                e.p = 1'b1;
                if (m_err < ERR_MAX) m_err++;
                m_miss++;
                if (m_miss == UNLOCK_CNT) m_state = 0;
            end
        end
        if (clr) m_err = 0;
        e.l   = (m_state == 2);
        e.e   = ERR_W'(m_err);
        e.led = e.l ? 4'(m_err % 16) : 4'(d);
        sb.push_back(e);
    endtask

    // Drive one strobe; consecutive calls produce back-to-back strobes.
    task automatic send(input int d, input bit clr = 1'b0);
        @(negedge clk);
        data_in    = 4'(d);
        data_valid = 1'b1;
        err_clr    = clr;
        model_step(d, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid = 1'b0;
            err_clr    = 1'b0;
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        data_valid = 1'b0;
        err_clr    = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_led", led, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        if (data_valid && !rst) begin
            #1;
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("locked", locked, e.l);
                check("err_pulse", err_pulse, e.p);
                check("err_cnt", err_cnt, e.e);
                check("led", led, e.led);
            end
        end else begin
            #1;
            check("pulse_idle", err_pulse, 0);
        end
    end

    initial begin
        rst        = 1'b1;
        data_in    = 4'd0;
        data_valid = 1'b0;
        err_clr    = 1'b0;
        model_reset();
        #3;
        check("init_locked", locked, 0);
        check("init_errcnt", err_cnt, 0);
        check("init_led", led, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic lock on 0001,0010,0100
        send(1); send(2); send(4);
        idle(2);
        // One bad sample while locked (0000 where 0011 expected)
        send(9); send(0); send(6);
        idle(2);
        // Two consecutive mismatches drop lock
        send(15); send(15);
        idle(2);

        async_reset();
        // Lockup value never seeds, then wrap 1000->0001 locks
        for (int i = 0; i < 5; i++) send(0);
        send(8); send(1); send(2);
        idle(1);
        send(4); send(9);
        idle(1);

        // Mid-stream reset, then a fresh relock is required
        async_reset();
        send(3); send(6);
        idle(1);
        send(13);
        idle(1);

        // Two counted errors, each followed by a correct value
        for (int i = 0; i < 2; i++) begin
            send(m_exp ^ 5);
            send(m_exp);
        end
`ifdef LFSR_CHK_ERR_CLR_EN
        send(m_exp ^ 5, 1'b1);
        send(m_exp);
`endif
        // Saturate the error counter
        for (int i = 0; i < ERR_MAX + 2; i++) begin
            send(m_exp ^ 3);
            send(m_exp);
        end
        idle(3);
        check("sat_errcnt", err_cnt, ERR_MAX);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
